// File: rtl/mod_src_arbiter.sv
// Round-robin share of the 8-to-5 repacker between two byte sources; 1-cycle arbitration, bytes pass combinationally in XFER.
// Backpressure: pk_ready is forwarded to the granted source; pad bytes hold on pk_ready low; ownership changes only on 5-byte groups.
module mod_src_arbiter #(
    parameter int GROUP_BYTES = 5,
    parameter int CW          = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  src_valid,
    input  logic [7:0]  src_data0,
    input  logic [7:0]  src_data1,
    input  logic [1:0]  src_last,
    output logic [1:0]  src_ready,
    output logic [7:0]  pk_data,
    output logic        pk_valid,
    output logic        pk_sof,
    input  logic        pk_ready,
    output logic [1:0]  grant,
    output logic        pad_active,
    output logic [15:0] pad_total
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        PAD  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(GROUP_BYTES - 1);

    state_t        r_state;
    logic [1:0]    r_grant;
    logic          r_rr_ptr;
    logic [CW-1:0] r_byte_cnt;
    logic [15:0]   r_pad_total;
    logic          r_first;

    logic          w_gsel;
    logic          w_win;
    logic          w_xfer;
    logic          w_last;
    logic          w_grp_end;
    logic [CW-1:0] w_cnt_nxt;

    assign w_gsel    = r_grant[1];
    assign w_win     = (src_valid == 2'b11) ? r_rr_ptr : src_valid[1];
    assign w_xfer    = pk_valid && pk_ready;
    assign w_last    = src_last[w_gsel];
    assign w_grp_end = (r_byte_cnt == LAST_CNT);
    assign w_cnt_nxt = w_grp_end ? '0 : r_byte_cnt + 1'b1;

    always_comb begin
        pk_data    = 8'h00;
        pk_valid   = 1'b0;
        pk_sof     = 1'b0;
        src_ready  = 2'b00;
        pad_active = 1'b0;
        case (r_state)
            XFER: begin
                pk_data           = w_gsel ? src_data1 : src_data0;
                pk_valid          = src_valid[w_gsel];
                pk_sof            = r_first && src_valid[w_gsel];
                src_ready[w_gsel] = pk_ready;
            end
            PAD: begin
                pk_valid   = 1'b1;
                pad_active = 1'b1;
            end
            default: ;
        endcase
    end

    assign grant     = r_grant;
    assign pad_total = r_pad_total;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_grant     <= 2'b00;
            r_rr_ptr    <= 1'b0;
            r_byte_cnt  <= '0;
            r_pad_total <= 16'h0000;
            r_first     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (src_valid != 2'b00) begin
                        r_grant    <= w_win ? 2'b10 : 2'b01;
                        r_rr_ptr   <= ~w_win;
                        r_byte_cnt <= '0;
                        r_first    <= 1'b1;
                        r_state    <= XFER;
                    end
                end
                XFER: begin
                    if (w_xfer) begin
                        r_first    <= 1'b0;
                        r_byte_cnt <= w_cnt_nxt;
                        if (w_last) begin
                            if (w_grp_end) begin
                                r_grant <= 2'b00;
                                r_state <= IDLE;
                            end else begin
                                r_state <= PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    if (w_xfer) begin
                        r_byte_cnt <= w_cnt_nxt;
                        if (r_pad_total != 16'hFFFF)
                            r_pad_total <= r_pad_total + 16'd1;
                        if (w_grp_end) begin
                            r_grant <= 2'b00;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_src_arbiter.sv
// Directed bench for mod_src_arbiter: inputs driven on the falling edge, outputs checked 1 ns later.
module tb_mod_src_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  src_valid;
    logic [7:0]  src_data0;
    logic [7:0]  src_data1;
    logic [1:0]  src_last;
    logic [1:0]  src_ready;
    logic [7:0]  pk_data;
    logic        pk_valid;
    logic        pk_sof;
    logic        pk_ready;
    logic [1:0]  grant;
    logic        pad_active;
    logic [15:0] pad_total;

    int n_chk = 0;
    int n_bad = 0;

    mod_src_arbiter #(.GROUP_BYTES(5), .CW(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .src_valid  (src_valid),
        .src_data0  (src_data0),
        .src_data1  (src_data1),
        .src_last   (src_last),
        .src_ready  (src_ready),
        .pk_data    (pk_data),
        .pk_valid   (pk_valid),
        .pk_sof     (pk_sof),
        .pk_ready   (pk_ready),
        .grant      (grant),
        .pad_active (pad_active),
        .pad_total  (pad_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycle(input logic [1:0] v);
        src_valid = v; src_last = 2'b00; pk_ready = 1'b1;
        #1;
        chk("idle_grant", grant, 2'b00);
        chk("idle_valid", pk_valid, 1'b0);
        chk("idle_data", pk_data, 8'h00);
        chk("idle_ready", src_ready, 2'b00);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] v, input logic [7:0] d, input logic last,
                        input logic sof, input logic [1:0] g);
        src_valid = v; src_data0 = d; src_data1 = d; src_last = {last, last}; pk_ready = 1'b1;
        #1;
        chk("xfer_grant", grant, g);
        chk("xfer_valid", pk_valid, 1'b1);
        chk("xfer_data", pk_data, d);
        chk("xfer_sof", pk_sof, sof);
        chk("xfer_ready", src_ready, g);
        chk("xfer_padact", pad_active, 1'b0);
        @(negedge clk);
    endtask

    task automatic pad_cycle(input logic [1:0] g);
        src_valid = 2'b00; src_last = 2'b00; pk_ready = 1'b1;
        #1;
        chk("pad_active", pad_active, 1'b1);
        chk("pad_valid", pk_valid, 1'b1);
        chk("pad_data", pk_data, 8'h00);
        chk("pad_ready", src_ready, 2'b00);
        chk("pad_sof", pk_sof, 1'b0);
        chk("pad_grant", grant, g);
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag, input logic [15:0] ptot);
        src_valid = 2'b00; src_last = 2'b00;
        #1;
        chk({tag, "_grant"}, grant, 2'b00);
        chk({tag, "_padact"}, pad_active, 1'b0);
        chk({tag, "_valid"}, pk_valid, 1'b0);
        chk({tag, "_ptot"}, pad_total, ptot);
        @(negedge clk);
    endtask

    initial begin
        logic       r;
        int         i;
        int         npad;
        int         guard;
        logic [1:0] gseq [4];
        gseq[0] = 2'b01; gseq[1] = 2'b10; gseq[2] = 2'b01; gseq[3] = 2'b10;

        reset_n = 1'b0; src_valid = 2'b00; src_data0 = 8'h00; src_data1 = 8'h00;
        src_last = 2'b00; pk_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_valid", pk_valid, 1'b0);
        chk("rst_data", pk_data, 8'h00);
        chk("rst_sof", pk_sof, 1'b0);
        chk("rst_ready", src_ready, 2'b00);
        chk("rst_padact", pad_active, 1'b0);
        chk("rst_ptot", pad_total, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        // source 0, exact 5-byte group, no pad
        idle_cycle(2'b01);
        for (int b = 1; b <= 5; b++)
            send(2'b01, 8'(b), b == 5, b == 1, 2'b01);
        check_quiet("t1", 16'd0);

        // source 1, 2 bytes then 3 pad bytes
        idle_cycle(2'b10);
        send(2'b10, 8'hAA, 1'b0, 1'b1, 2'b10);
        send(2'b10, 8'hBB, 1'b1, 1'b0, 2'b10);
        for (int p = 0; p < 3; p++) pad_cycle(2'b10);
        check_quiet("t2", 16'd3);

        // both requesting: grants alternate per packet
        for (int k = 0; k < 4; k++) begin
            idle_cycle(2'b11);
            for (int b = 0; b < 5; b++)
                send(2'b11, 8'(8'h40 + 8'(k * 8 + b)), b == 4, b == 0, gseq[k]);
        end
        check_quiet("t3", 16'd3);

        // 7-byte packet with pk_ready toggling 1010 through XFER and PAD
        idle_cycle(2'b01);
        i = 0; r = 1'b1;
        while (i < 7) begin
            src_valid = 2'b01; src_data0 = 8'(8'h11 + 8'(i)); src_last = {1'b0, i == 6};
            pk_ready = r;
            #1;
            chk("tog_data", pk_data, 8'(8'h11 + 8'(i)));
            chk("tog_ready", src_ready, {1'b0, r});
            if (i == 0) chk("tog_sof", pk_sof, 1'b1);
            @(negedge clk);
            if (r) i++;
            r = ~r;
        end
        npad = 0; guard = 0;
        while (npad < 3 && guard < 20) begin
            src_valid = 2'b00; src_last = 2'b00; pk_ready = r;
            #1;
            chk("tpad_active", pad_active, 1'b1);
            chk("tpad_data", pk_data, 8'h00);
            chk("tpad_valid", pk_valid, 1'b1);
            chk("tpad_ready", src_ready, 2'b00);
            @(negedge clk);
            if (r) npad++;
            r = ~r;
            guard++;
        end
        chk("tpad_count", npad, 3);
        pk_ready = 1'b1;
        check_quiet("t4", 16'd6);

        // stall: source 0 drops valid for 4 cycles after byte 2
        idle_cycle(2'b01);
        send(2'b01, 8'h21, 1'b0, 1'b1, 2'b01);
        send(2'b01, 8'h22, 1'b0, 1'b0, 2'b01);
        for (int s = 0; s < 4; s++) begin
            src_valid = 2'b00; pk_ready = 1'b1;
            #1;
            chk("stall_grant", grant, 2'b01);
            chk("stall_valid", pk_valid, 1'b0);
            chk("stall_padact", pad_active, 1'b0);
            @(negedge clk);
        end
        send(2'b01, 8'h23, 1'b0, 1'b0, 2'b01);
        send(2'b01, 8'h24, 1'b0, 1'b0, 2'b01);
        send(2'b01, 8'h25, 1'b1, 1'b0, 2'b01);
        check_quiet("t5", 16'd6);

        // reset mid-pad after one pad byte
        idle_cycle(2'b10);
        send(2'b10, 8'h31, 1'b0, 1'b1, 2'b10);
        send(2'b10, 8'h32, 1'b1, 1'b0, 2'b10);
        pad_cycle(2'b10);
        #1;
        chk("prerst_ptot", pad_total, 16'd7);
        reset_n = 1'b0;
        #1;
        chk("arst_grant", grant, 2'b00);
        chk("arst_valid", pk_valid, 1'b0);
        chk("arst_padact", pad_active, 1'b0);
        chk("arst_ptot", pad_total, 16'd0);
        chk("arst_ready", src_ready, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycle(2'b10);
        for (int b = 1; b <= 5; b++)
            send(2'b10, 8'(8'h50 + 8'(b)), b == 5, b == 1, 2'b10);
        check_quiet("t6", 16'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
